// File: rtl/grid_ingest.sv
// grid_ingest: byte-stream parser that turns '@' / '.' / newline text into a
// WIDTH x DEPTH bit grid (1 = paper) and hands it to the removal engine with
// a valid/ack handshake. Also reports the paper count and sticky parse errors.
module grid_ingest #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH*DEPTH-1:0]           grid_flat,
    output logic                             grid_valid,
    input  logic                             grid_ack,
    output logic [$clog2(DEPTH+1)-1:0]       rows_loaded,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0] paper_count,
    output logic                             error,
    output logic [1:0]                       err_code
);

    localparam int RW   = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int PW   = $clog2(WIDTH * DEPTH + 1);
    localparam int IDXW = $clog2(WIDTH * DEPTH);

    localparam logic [7:0] CH_PAPER = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic [1:0] {
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t               state_q;
    logic [WIDTH*DEPTH-1:0] grid_q;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [PW-1:0]        paper_q;
    logic [1:0]           errCode_q;
    logic                 gridValid_q;
    logic                 error_q;

    logic [IDXW-1:0]      bitIdx_d;
    logic                 colFull_d;

    // Flat bit position of the current (row, col) cursor and the row-full test.
    always_comb begin
        bitIdx_d  = IDXW'(int'(row_q) * WIDTH + int'(col_q));
        colFull_d = (col_q == CW'(WIDTH));
    end

    // Parser FSM with its grid, cursor, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            grid_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            paper_q     <= '0;
            errCode_q   <= 2'b00;
            gridValid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        case (in_data)
                            CH_PAPER: begin
                                if (colFull_d) begin
                                    state_q   <= ERR;
                                    errCode_q <= ERR_OVERFLOW;
                                    error_q   <= 1'b1;
                                end else begin
                                    grid_q[bitIdx_d] <= 1'b1;
                                    col_q            <= col_q + CW'(1);
                                    paper_q          <= paper_q + PW'(1);
                                end
                            end
                            CH_EMPTY: begin
                                if (colFull_d) begin
                                    state_q   <= ERR;
                                    errCode_q <= ERR_OVERFLOW;
                                    error_q   <= 1'b1;
                                end else begin
                                    col_q <= col_q + CW'(1);
                                end
                            end
                            CH_CR: begin
                            end
                            CH_LF: begin
                                if (col_q != '0) begin
                                    row_q <= row_q + RW'(1);
                                    col_q <= '0;
                                    if (row_q == RW'(DEPTH - 1)) begin
                                        state_q     <= DONE;
                                        gridValid_q <= 1'b1;
                                    end
                                end else if (row_q != '0) begin
                                    state_q     <= DONE;
                                    gridValid_q <= 1'b1;
                                end
                            end
                            default: begin
                                state_q   <= ERR;
                                errCode_q <= ERR_ILLEGAL;
                                error_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (grid_ack) begin
                        state_q     <= LOAD;
                        grid_q      <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                        paper_q     <= '0;
                        gridValid_q <= 1'b0;
                    end
                end
                ERR: begin
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Reset blocks the handshake in the same cycle so no byte slips past it.
    always_comb begin
        in_ready    = (state_q == LOAD) && !reset;
        grid_flat   = grid_q;
        grid_valid  = gridValid_q;
        rows_loaded = row_q;
        paper_count = paper_q;
        error       = error_q;
        err_code    = errCode_q;
    end

endmodule

// File: tb/tb_grid_ingest.sv
// tb_grid_ingest: drives directed text vectors into a 4x3 grid_ingest and
// compares every cycle against a text-level parser model kept in the bench,
// plus literal grid values worked out by hand for each vector.
module tb_grid_ingest;

    localparam int W  = 4;
    localparam int D  = 3;
    localparam int RW = $clog2(D + 1);
    localparam int PW = $clog2(W * D + 1);

    logic             clk;
    logic             reset;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W*D-1:0]   grid_flat;
    logic             grid_valid;
    logic             grid_ack;
    logic [RW-1:0]    rows_loaded;
    logic [PW-1:0]    paper_count;
    logic             error;
    logic [1:0]       err_code;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    // Model of the parser: what has been written into the grid so far.
    bit mGrid [D][W];
    int mRow;
    int mCol;
    int mPaper;
    int mMode;
    int mErr;

    grid_ingest #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .grid_flat  (grid_flat),
        .grid_valid (grid_valid),
        .grid_ack   (grid_ack),
        .rows_loaded(rows_loaded),
        .paper_count(paper_count),
        .error      (error),
        .err_code   (err_code)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wipe the model back to an empty grid awaiting the first row.
    task automatic modelClear();
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++)
                mGrid[r][c] = 1'b0;
        mRow   = 0;
        mCol   = 0;
        mPaper = 0;
    endtask

    // Apply the text-parsing rules to one accepted character.
    task automatic modelByte(input logic [7:0] b);
        if (b == "@" || b == ".") begin
            if (mCol == W) begin
                mMode = 2;
                mErr  = 2;
            end else begin
                if (b == "@") begin
                    mGrid[mRow][mCol] = 1'b1;
                    mPaper++;
                end
                mCol++;
            end
        end else if (b == 8'h0D) begin
        end else if (b == 8'h0A) begin
            if (mCol > 0) begin
                mRow++;
                mCol = 0;
                if (mRow == D) mMode = 1;
            end else if (mRow > 0) begin
                mMode = 1;
            end
        end else begin
            mMode = 2;
            mErr  = 1;
        end
    endtask

    // Advance the model on each edge from the inputs the bench is presenting.
    initial begin
        modelClear();
        mMode = 0;
        mErr  = 0;
    end
    always @(posedge clk) begin
        if (reset) begin
            modelClear();
            mMode = 0;
            mErr  = 0;
        end else if (mMode == 0 && in_valid) begin
            modelByte(in_data);
        end else if (mMode == 1 && grid_ack) begin
            modelClear();
            mMode = 0;
        end
    end

    // Every cycle, away from the active edge, hold the DUT against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [W*D-1:0] flat;
            flat = '0;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < W; c++)
                    flat[r*W+c] = mGrid[r][c];
            checkOutput("model grid_flat",   64'(grid_flat),   64'(flat));
            checkOutput("model grid_valid",  64'(grid_valid),  64'(mMode == 1));
            checkOutput("model error",       64'(error),       64'(mMode == 2));
            checkOutput("model err_code",    64'(err_code),    64'(mErr));
            checkOutput("model rows_loaded", 64'(rows_loaded), 64'(mRow));
            checkOutput("model paper_count", 64'(paper_count), 64'(mPaper));
            checkOutput("model in_ready",    64'(in_ready),    64'(mMode == 0 && !reset));
        end
    end

    // Send a string one character per cycle; with gaps, idle a cycle between
    // characters while showing a junk byte that must not be taken.
    task automatic applyStimulus(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (gaps) begin
                in_data = "x";
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Synchronous reset for two edges, released just after an edge.
    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Directed scenarios with literal expectations worked out by hand.
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        grid_ack = 1'b0;
        @(posedge clk);
        checkEn = 1;
        #1;
        @(negedge clk);
        checkOutput("reset grid_flat", 64'(grid_flat), 64'h0);
        checkOutput("reset in_ready",  64'(in_ready),  64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset in_ready", 64'(in_ready), 64'h1);

        // Full load: rows 1100 / 0111 / 0010, grid_valid one cycle later.
        applyStimulus("..@@\n@@@.\n.@..\n", 1'b0);
        @(negedge clk);
        checkOutput("full grid_flat",   64'(grid_flat),   64'h27C);
        checkOutput("full paper_count", 64'(paper_count), 64'd6);
        checkOutput("full rows_loaded", 64'(rows_loaded), 64'd3);
        checkOutput("full grid_valid",  64'(grid_valid),  64'h1);
        checkOutput("full in_ready",    64'(in_ready),    64'h0);

        // Hold without ack for 5 cycles: the grid must not move.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold grid_flat",  64'(grid_flat),  64'h27C);
            checkOutput("hold grid_valid", 64'(grid_valid), 64'h1);
        end
        @(posedge clk);
        #1;
        grid_ack = 1'b1;
        @(posedge clk);
        #1;
        grid_ack = 1'b0;
        @(negedge clk);
        checkOutput("ack grid_flat",   64'(grid_flat),   64'h0);
        checkOutput("ack in_ready",    64'(in_ready),    64'h1);
        checkOutput("ack grid_valid",  64'(grid_valid),  64'h0);
        checkOutput("ack paper_count", 64'(paper_count), 64'd0);

        // Second grid after reload: diagonal 0001 / 0010 / 0100.
        applyStimulus("@...\n.@..\n..@.\n", 1'b0);
        @(negedge clk);
        checkOutput("reload grid_flat",   64'(grid_flat),   64'h421);
        checkOutput("reload paper_count", 64'(paper_count), 64'd3);
        grid_ack = 1'b1;
        @(posedge clk);
        #1;
        grid_ack = 1'b0;

        // Short rows then blank line: 0001 / 0010 / 0000, two rows.
        applyStimulus("@\n.@\n\n", 1'b0);
        @(negedge clk);
        checkOutput("short grid_flat",   64'(grid_flat),   64'h021);
        checkOutput("short rows_loaded", 64'(rows_loaded), 64'd2);
        checkOutput("short grid_valid",  64'(grid_valid),  64'h1);
        pulseReset();

        // Leading blank line is ignored, then backpressure with a CR.
        applyStimulus("\n@.\r\n", 1'b1);
        @(negedge clk);
        checkOutput("bp grid_flat",   64'(grid_flat),   64'h001);
        checkOutput("bp rows_loaded", 64'(rows_loaded), 64'd1);
        checkOutput("bp paper_count", 64'(paper_count), 64'd1);
        checkOutput("bp grid_valid",  64'(grid_valid),  64'h0);
        pulseReset();

        // Row overflow on the fifth '@'.
        applyStimulus("@@@@@", 1'b0);
        @(negedge clk);
        checkOutput("ovf error",     64'(error),     64'h1);
        checkOutput("ovf err_code",  64'(err_code),  64'h2);
        checkOutput("ovf grid_flat", 64'(grid_flat), 64'h00F);
        checkOutput("ovf in_ready",  64'(in_ready),  64'h0);
        applyStimulus("@\n", 1'b0);
        @(negedge clk);
        checkOutput("ovf frozen", 64'(paper_count), 64'd4);
        pulseReset();

        // Illegal character.
        applyStimulus(".x", 1'b0);
        @(negedge clk);
        checkOutput("illegal err_code", 64'(err_code), 64'h1);
        checkOutput("illegal error",    64'(error),    64'h1);
        pulseReset();

        // Reset mid-row, coinciding with a valid byte.
        applyStimulus("@@", 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = "@";
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset grid_flat",   64'(grid_flat),   64'h0);
        checkOutput("midreset paper_count", 64'(paper_count), 64'd0);
        checkOutput("midreset in_ready",    64'(in_ready),    64'h1);
        applyStimulus(".@\n\n", 1'b0);
        @(negedge clk);
        checkOutput("after reset grid_flat", 64'(grid_flat),   64'h002);
        checkOutput("after reset rows",      64'(rows_loaded), 64'd1);
        checkOutput("after reset valid",     64'(grid_valid),  64'h1);

        @(posedge clk);
        #1;
        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
